ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Carries the decoder's 9-bit control word from decode through the EX, MEM and WB pipeline registers, as the consumer end of the decode control bus. Each stage reads its own subset of the word. The block generates the decode stall for multi-cycle multiply and for memory back-pressure, and squashes the decode-slot instruction when a taken branch or jump leaves EX. It sits between the decode stage and the execute/memory/writeback datapaths.

## Interface
- MUL_CYCLES, 3: cycles a MUL occupies EX (≥1); used only with the multi-cycle multiply macro.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_ctrl  in  9  control word, bit 8..0 = regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite, jump, word
- id_rd  in  5  destination register
- id_mul  in  1  decode instruction is MUL (opcode 0x02)
- ex_zero  in  1  ALU zero flag for the instruction in EX
- mem_busy  in  1  data memory cannot complete this cycle
- id_stall  out  1  decode must hold its instruction
- redirect  out  1  one-cycle pulse, taken branch/jump left EX
- ex_valid, ex_ctrl[8:0], ex_rd[4:0]  out  EX stage register contents
- mem_valid, mem_read, mem_write, mem_word  out  MEM stage; read/write/word gated by mem_valid
- mem_rd  out  5  MEM destination register
- wb_valid, wb_reg_write, wb_mem_to_reg  out  WB stage; reg_write gated by wb_valid
- wb_rd  out  5  WB destination register

## Operation
- Stage registers EX, MEM, WB: each holds valid, ctrl[8:0], rd[4:0]. EX also holds mul and mul_cnt.
- mem_hold = mem_valid & mem_busy & (memRead | memWrite). mem_busy is ignored otherwise.
- ex_hold = ex_valid & ex_mul & (mul_cnt != 0).
- id_stall = mem_hold | ex_hold. This path is combinational.
- take = ex_valid & (jump | (branch & ex_zero)). redirect = take & ~id_stall.
- WB: when ~mem_hold, WB loads MEM. When mem_hold, WB loads a bubble (valid=0).
- MEM: when mem_hold, MEM holds. Otherwise, if ex_hold, MEM loads a bubble. Otherwise MEM loads EX.
- EX: when id_stall, EX holds. Otherwise EX loads id_*, with valid = id_valid & ~take. When take is set, the decode-slot instruction is squashed.
- mul_cnt: loads MUL_CYCLES-1 when a valid MUL enters EX. It decrements while nonzero, independent of mem_hold, and saturates at 0.
- A bubble's ctrl/rd contents are don't-care. All gated outputs are 0 for bubbles.
- Opcodes the decoder does not recognise arrive as whatever id_ctrl holds. They are propagated unchanged and are not checked.

## Timing
- Reset: all valid=0, all ctrl=0, all rd=0, mul_cnt=0. Consequently id_stall=0, redirect=0, and all gated outputs are 0.
- Reset mid-operation clears every stage in the same edge. Reset overrides stall and redirect.
- No stall: an instruction accepted at edge N is in EX after N, in MEM after N+1, and in WB after N+2. ID to WB latency is 3 edges.
- MUL: occupies EX for MUL_CYCLES cycles. id_stall is high for MUL_CYCLES-1 cycles, and one bubble enters MEM per stalled cycle.
- Memory stall: holds MEM and EX, and inserts a WB bubble each cycle.
- Simultaneous mem_hold and ex_hold: both stages hold, and mul_cnt still decrements.
- A taken branch held in EX by mem_hold: redirect stays low until the branch leaves EX, then pulses for exactly 1 cycle.
- Back-to-back MULs: the second MUL reloads the counter when it enters EX.

## Configuration
- CTRL_PIPE_MUL_MC_EN defined: MUL behaves as described above, occupying EX for MUL_CYCLES cycles.
- CTRL_PIPE_MUL_MC_EN undefined: mul_cnt is removed, ex_hold is 0, MUL is single-cycle, and MUL_CYCLES is ignored.

## Test plan
- Reset mid-stream: with 3 valid ADDs in flight, assert reset for 1 cycle → next cycle all valid=0, id_stall=0, redirect=0, wb_reg_write=0.
- ADD, id_ctrl=9'b100000100, id_rd=5, accepted at edge N → after N+2, wb_valid=1, wb_reg_write=1, wb_rd=5, wb_mem_to_reg=0.
- Macro on, MUL_CYCLES=3, MUL then ADD → id_stall high 2 cycles, 2 MEM bubbles, ADD reaches WB 2 cycles later than unstalled.
- BEQ (9'b010000000) with ex_zero=1, followed by STW → redirect 1-cycle pulse; the STW never gives mem_valid=1 or mem_write=1.
- LDW (9'b001101101) with mem_busy high for 2 cycles while in MEM → id_stall high 2 cycles, 2 WB bubbles, then wb_mem_to_reg=1 and wb_reg_write=1.
- Macro off: MUL followed by ADD → id_stall never asserts, and both reach WB on consecutive cycles.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decode control word through the EX/MEM/WB registers, generating the decode stall and branch redirect.
// Define CTRL_PIPE_MUL_MC_EN to make a MUL hold EX for MUL_CYCLES cycles; otherwise MUL is single-cycle.
module ctrl_pipe #(
   parameter int MUL_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [8:0] id_ctrl,
   input  logic [4:0] id_rd,
   input  logic       id_mul,
   input  logic       ex_zero,
   input  logic       mem_busy,
   output logic       id_stall,
   output logic       redirect,
   output logic       ex_valid,
   output logic [8:0] ex_ctrl,
   output logic [4:0] ex_rd,
   output logic       mem_valid,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_word,
   output logic [4:0] mem_rd,
   output logic       wb_valid,
   output logic       wb_reg_write,
   output logic       wb_mem_to_reg,
   output logic [4:0] wb_rd
);
   localparam int B_BRANCH     = 7;
   localparam int B_MEM_READ   = 6;
   localparam int B_MEM_TO_REG = 5;
   localparam int B_MEM_WRITE  = 4;
   localparam int B_REG_WRITE  = 2;
   localparam int B_JUMP       = 1;
   localparam int B_WORD       = 0;

   logic [8:0] mem_ctrl;
   logic [8:0] wb_ctrl;
   logic       ex_mul;
   logic       mem_hold;
   logic       ex_hold;
   logic       take;

   assign mem_hold = mem_valid & mem_busy & (mem_ctrl[B_MEM_READ] | mem_ctrl[B_MEM_WRITE]);
   assign take     = ex_valid & (ex_ctrl[B_JUMP] | (ex_ctrl[B_BRANCH] & ex_zero));
   assign id_stall = mem_hold | ex_hold;
   // A branch held in EX must not redirect until it actually leaves.
   assign redirect = take & ~id_stall;

`ifdef CTRL_PIPE_MUL_MC_EN
   localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   logic [CW-1:0] mul_cnt;

   assign ex_hold = ex_valid & ex_mul & (mul_cnt != '0);

   always_ff @(posedge clk) begin
      if (reset)
         mul_cnt <= '0;
      else if (~id_stall & id_valid & ~take & id_mul)
         mul_cnt <= CW'(MUL_CYCLES - 1);
      else if (mul_cnt != '0)
         mul_cnt <= mul_cnt - 1'b1;
   end
`else
   localparam int unused_mul_cycles = MUL_CYCLES;
   logic unused_mul;
   assign unused_mul = ex_mul;
   assign ex_hold    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_rd    <= '0;
         ex_mul   <= 1'b0;
      end else if (~id_stall) begin
         ex_valid <= id_valid & ~take;
         ex_ctrl  <= id_ctrl;
         ex_rd    <= id_rd;
         ex_mul   <= id_mul;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid <= 1'b0;
         mem_ctrl  <= '0;
         mem_rd    <= '0;
      end else if (~mem_hold) begin
         if (ex_hold) begin
            mem_valid <= 1'b0;
         end else begin
            mem_valid <= ex_valid;
            mem_ctrl  <= ex_ctrl;
            mem_rd    <= ex_rd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid <= 1'b0;
         wb_ctrl  <= '0;
         wb_rd    <= '0;
      end else if (mem_hold) begin
         wb_valid <= 1'b0;
      end else begin
         wb_valid <= mem_valid;
         wb_ctrl  <= mem_ctrl;
         wb_rd    <= mem_rd;
      end
   end

   assign mem_read      = mem_valid & mem_ctrl[B_MEM_READ];
   assign mem_write     = mem_valid & mem_ctrl[B_MEM_WRITE];
   assign mem_word      = mem_valid & mem_ctrl[B_WORD];
   assign wb_reg_write  = wb_valid & wb_ctrl[B_REG_WRITE];
   assign wb_mem_to_reg = wb_valid & wb_ctrl[B_MEM_TO_REG];

   // WB only consumes two fields of the word; the rest travel along for visibility.
   logic unused_wb;
   assign unused_wb = &{1'b0, wb_ctrl[8:6], wb_ctrl[4:3], wb_ctrl[1:0]};
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus randomized traffic against an instruction-order scoreboard for ctrl_pipe.
module tb_ctrl_pipe;
   localparam int MUL_CYCLES = 3;
   localparam logic [8:0] C_ADD = 9'b100000100;
   localparam logic [8:0] C_BEQ = 9'b010000000;
   localparam logic [8:0] C_STW = 9'b000011001;
   localparam logic [8:0] C_LDW = 9'b001101101;

   logic       clk = 1'b0;
   logic       reset, id_valid, id_mul, ex_zero, mem_busy;
   logic [8:0] id_ctrl;
   logic [4:0] id_rd;
   logic       id_stall, redirect, ex_valid, mem_valid, mem_read, mem_write, mem_word;
   logic       wb_valid, wb_reg_write, wb_mem_to_reg;
   logic [8:0] ex_ctrl;
   logic [4:0] ex_rd, mem_rd, wb_rd;

   ctrl_pipe #(.MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rd(id_rd),
      .id_mul(id_mul), .ex_zero(ex_zero), .mem_busy(mem_busy), .id_stall(id_stall),
      .redirect(redirect), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
      .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write), .mem_word(mem_word),
      .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0] ctrl;
      logic [4:0] rd;
   } ins_t;

   ins_t       mem_q[$];
   ins_t       wb_q[$];
   int         checks = 0;
   int         failures = 0;
   logic       prev_live = 1'b0;
   logic [8:0] prev_ctrl = '0;
   logic       s_stall, s_redirect;
   int         cyc_n = 0;
   int         wb_at[32];
   bit         mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // One clock of decode traffic; the reference model sees decode slots in program order.
   task automatic cyc(input logic rst, input logic v, input logic [8:0] c, input logic [4:0] r,
                      input logic m, input logic z, input logic b, output logic acc);
      logic take_m;
      reset = rst; id_valid = v; id_ctrl = c; id_rd = r; id_mul = m; ex_zero = z; mem_busy = b;
      @(negedge clk); #1;
      s_stall    = id_stall;
      s_redirect = redirect;
      take_m = prev_live && (prev_ctrl[1] || (prev_ctrl[7] && z));
      if (!rst) chk("redirect", redirect, !s_stall && take_m);
      @(posedge clk);
      acc = 1'b0;
      if (rst) begin
         mem_q.delete();
         wb_q.delete();
         prev_live = 1'b0;
      end else if (!s_stall) begin
         acc       = 1'b1;
         prev_live = v && !take_m;
         prev_ctrl = c;
         if (v && !take_m) begin
            mem_q.push_back('{ctrl: c, rd: r});
            wb_q.push_back('{ctrl: c, rd: r});
         end
      end
      #1;
      cyc_n++;
      if (wb_valid === 1'b1) wb_at[wb_rd] = cyc_n;
   endtask

   initial begin : monitor
      ins_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (mem_valid === 1'b1) begin
               if (mem_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL mem_unexpected actual rd=%0d required=no instruction", mem_rd);
               end else begin
                  e = mem_q[0];
                  chk("mem_read", mem_read, e.ctrl[6]);
                  chk("mem_write", mem_write, e.ctrl[4]);
                  chk("mem_word", mem_word, e.ctrl[0]);
                  chk("mem_rd", mem_rd, e.rd);
                  if (!(mem_busy && (e.ctrl[6] || e.ctrl[4]))) void'(mem_q.pop_front());
               end
            end else begin
               chk("mem_gated", {mem_read, mem_write, mem_word}, 0);
            end
            if (wb_valid === 1'b1) begin
               if (wb_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL wb_unexpected actual rd=%0d required=no instruction", wb_rd);
               end else begin
                  e = wb_q.pop_front();
                  chk("wb_reg_write", wb_reg_write, e.ctrl[2]);
                  chk("wb_mem_to_reg", wb_mem_to_reg, e.ctrl[5]);
                  chk("wb_rd", wb_rd, e.rd);
               end
            end else begin
               chk("wb_gated", {wb_reg_write, wb_mem_to_reg}, 0);
            end
         end
      end
   end

   initial begin
      logic acc;
      int   st, cnt, n0, exp_st, exp_lat;
      logic pv, pm;
      logic [8:0] pc;
      logic [4:0] pr;

      for (int i = 0; i < 32; i++) wb_at[i] = -1;
      cyc(1, 0, '0, '0, 0, 0, 0, acc);
      cyc(1, 0, '0, '0, 0, 0, 0, acc);
      mon_en = 1'b1;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_ctrl_rd", {ex_ctrl, ex_rd, mem_rd, wb_rd}, 0);
      cyc(0, 0, '0, '0, 0, 0, 0, acc);
      chk("rst_id_stall", s_stall, 0);
      chk("rst_redirect", s_redirect, 0);

      // ADD flows ID->EX->MEM->WB in three edges
      cyc(0, 1, C_ADD, 5'd5, 0, 0, 0, acc);
      chk("add_ex", {ex_valid, ex_ctrl, ex_rd}, {1'b1, C_ADD, 5'd5});
      cyc(0, 0, '0, '0, 0, 0, 0, acc);
      chk("add_mem", {mem_valid, mem_rd, mem_read, mem_write}, {1'b1, 5'd5, 2'b00});
      cyc(0, 0, '0, '0, 0, 0, 0, acc);
      chk("add_wb", {wb_valid, wb_reg_write, wb_rd, wb_mem_to_reg}, {2'b11, 5'd5, 1'b0});
      cyc(0, 0, '0, '0, 0, 0, 0, acc);

      // Taken BEQ squashes the following STW
      cyc(0, 1, C_BEQ, 5'd0, 0, 0, 0, acc);
      cnt = 0; st = 0;
      cyc(0, 1, C_STW, 5'd9, 0, 1, 0, acc);
      cnt += int'(s_redirect);
      chk("beq_squash_ex", ex_valid, 0);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0, '0, '0, 0, 0, 0, acc);
         cnt += int'(s_redirect);
         st += int'(mem_write);
      end
      chk("beq_redirect_pulses", cnt, 1);
      chk("beq_stw_no_write", st, 0);

      // LDW held in MEM by two busy cycles
      cyc(0, 1, C_LDW, 5'd6, 0, 0, 0, acc);
      cyc(0, 0, '0, '0, 0, 0, 0, acc);
      st = 0; cnt = 0;
      for (int k = 0; k < 2; k++) begin
         cyc(0, 0, '0, '0, 0, 0, 1, acc);
         st  += int'(s_stall);
         cnt += int'(!wb_valid);
      end
      chk("ldw_stall_cycles", st, 2);
      chk("ldw_wb_bubbles", cnt, 2);
      cyc(0, 0, '0, '0, 0, 0, 0, acc);
      chk("ldw_release_stall", s_stall, 0);
      chk("ldw_wb", {wb_valid, wb_mem_to_reg, wb_reg_write, wb_rd}, {3'b111, 5'd6});
      for (int k = 0; k < 3; k++) cyc(0, 0, '0, '0, 0, 0, 0, acc);

      // MUL followed by ADD
`ifdef CTRL_PIPE_MUL_MC_EN
      exp_st = MUL_CYCLES - 1;
`else
      exp_st = 0;
`endif
      exp_lat = 3 + exp_st;
      cyc(0, 1, C_ADD, 5'd7, 1, 0, 0, acc);
      n0 = cyc_n; st = 0; acc = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) begin
         cyc(0, 1, C_ADD, 5'd8, 0, 0, 0, acc);
         st += int'(s_stall);
      end
      for (int k = 0; k < 8; k++) cyc(0, 0, '0, '0, 0, 0, 0, acc);
      chk("mul_stall_cycles", st, exp_st);
      chk("mul_wb_latency", wb_at[7] - n0, exp_lat - 1);
      chk("mul_add_wb_latency", wb_at[8] - n0, exp_lat);

      // Reset with three ADDs in flight
      cyc(0, 1, C_ADD, 5'd1, 0, 0, 0, acc);
      cyc(0, 1, C_ADD, 5'd2, 0, 0, 0, acc);
      cyc(0, 1, C_ADD, 5'd3, 0, 0, 0, acc);
      cyc(1, 0, '0, '0, 0, 0, 0, acc);
      chk("midrst_valids", {ex_valid, mem_valid, wb_valid}, 0);
      chk("midrst_wb_reg_write", wb_reg_write, 0);
      cyc(0, 0, '0, '0, 0, 0, 0, acc);
      chk("midrst_stall_redirect", {s_stall, s_redirect}, 0);

      // Randomized traffic; the producer holds its instruction while stalled
      acc = 1'b1;
      pv = 0; pc = '0; pr = '0; pm = 0;
      for (int i = 0; i < 1500; i++) begin
         if (acc) begin
            pv = ($urandom_range(0, 3) != 0);
            pc = 9'($urandom);
            pc[1] = ($urandom_range(0, 7) == 0);
            pr = 5'($urandom);
            pm = ($urandom_range(0, 3) == 0);
         end
         cyc(0, pv, pc, pr, pm, 1'($urandom), ($urandom_range(0, 2) == 0), acc);
      end
      for (int k = 0; k < 20; k++) cyc(0, 0, '0, '0, 0, 0, 0, acc);
      chk("drain_mem_q", mem_q.size(), 0);
      chk("drain_wb_q", wb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
